// File: rtl/program_counter_unit_pkg.sv
// Shared definitions for the program counter unit: next-PC mode encodings
// and small decode helpers used by the top level.
package program_counter_unit_pkg;

  localparam int PC_SEL_W = 3;

  // 6 and 7 are deliberately left unnamed; the top level treats them as SEQ.
  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JREG   = 3'd3,
    PC_RET    = 3'd4,
    PC_LOAD   = 3'd5
  } pc_sel_e;

  function automatic logic is_call_mode(input logic [PC_SEL_W-1:0] sel);
    return (sel == PC_JUMP) || (sel == PC_JREG) || (sel == PC_RET);
  endfunction

endpackage

// File: rtl/program_counter_unit_return_stack.sv
// Return-address stack: circular LIFO with head pointer and entry count.
// A push onto a full stack overwrites the oldest entry; push+pop replaces the top.
module return_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic             pop_eff;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_eff = pop && !empty;

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = head_q;
    if (push && pop_eff) begin
      wr_en  = 1'b1;
    end else if (push) begin
      // Head wraps naturally, so a full stack overwrites its oldest slot.
      head_d = head_q + PW'(1);
      wr_idx = head_q + PW'(1);
      wr_en  = 1'b1;
      if (!full) count_d = count_q + CW'(1);
    end else if (pop_eff) begin
      head_d  = head_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      if (wr_en) mem_q[wr_idx] <= pushData;
    end
  end

  assign top   = empty ? '0 : mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/program_counter_unit.sv
// Program counter with internal next-PC selection (seq/branch/jump/jreg/ret/load),
// a return-address stack and sticky RAS overflow/underflow flags. One register stage.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              INCR         = 4,
  parameter int              RAS_DEPTH    = 4,
  localparam int             CW           = $clog2(RAS_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [2:0]       pcSel,
  input  logic             branchTaken,
  input  logic [15:0]      immOffset,
  input  logic [25:0]      jumpTarget,
  input  logic [WIDTH-1:0] regTarget,
  input  logic [WIDTH-1:0] newCount,
  input  logic             call,
  output logic [WIDTH-1:0] currentCount,
  output logic [3:0]       lastFourBits,
  output logic [WIDTH-1:0] returnAddr,
  output logic [CW-1:0]    rasCount,
  output logic             rasOverflow,
  output logic             rasUnderflow
);

  // Assertion is immediate through the async clears; release reaches the
  // datapath two clk edges after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] seq, br_tgt, jmp_tgt, imm_ext;
  logic             ras_push, ras_pop, ras_full, ras_empty;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_count;

  assign seq     = pc_q + WIDTH'(INCR);
  assign imm_ext = {{(WIDTH-18){immOffset[15]}}, immOffset, 2'b00};
  assign br_tgt  = seq + imm_ext;
  assign jmp_tgt = {seq[WIDTH-1:28], jumpTarget, 2'b00};

  always_comb begin
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!stall) begin
      case (pc_sel_e'(pcSel))
        PC_SEQ:    pc_d = seq;
        PC_BRANCH: pc_d = branchTaken ? br_tgt : seq;
        PC_JUMP:   pc_d = jmp_tgt;
        PC_JREG:   pc_d = regTarget;
        PC_LOAD:   pc_d = newCount;
        PC_RET: begin
          if (ras_empty) begin
            pc_d  = regTarget;
            udf_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
        default:   pc_d = seq;
      endcase
      ras_push = call && is_call_mode(pcSel);
      // A simultaneous pop frees the top slot, so push+pop never overflows.
      if (ras_push && ras_full && !ras_pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .pushData (seq),
    .top      (ras_top),
    .count    (ras_count),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  assign currentCount = pc_q;
  assign lastFourBits = pc_q[WIDTH-1:WIDTH-4];
  assign returnAddr   = ras_top;
  assign rasCount     = ras_count;
  assign rasOverflow  = ovf_q;
  assign rasUnderflow = udf_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed-vector bench for program_counter_unit (WIDTH=32, RAS_DEPTH=4).
module tb_program_counter_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [2:0]  pcSel;
  logic        branchTaken;
  logic [15:0] immOffset;
  logic [25:0] jumpTarget;
  logic [31:0] regTarget;
  logic [31:0] newCount;
  logic        call;
  logic [31:0] currentCount;
  logic [3:0]  lastFourBits;
  logic [31:0] returnAddr;
  logic [2:0]  rasCount;
  logic        rasOverflow;
  logic        rasUnderflow;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [2:0] SEQ = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, JREG = 3'd3, RET = 3'd4, LOAD = 3'd5;

  always #5 clk = ~clk;

  program_counter_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .pcSel        (pcSel),
    .branchTaken  (branchTaken),
    .immOffset    (immOffset),
    .jumpTarget   (jumpTarget),
    .regTarget    (regTarget),
    .newCount     (newCount),
    .call         (call),
    .currentCount (currentCount),
    .lastFourBits (lastFourBits),
    .returnAddr   (returnAddr),
    .rasCount     (rasCount),
    .rasOverflow  (rasOverflow),
    .rasUnderflow (rasUnderflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic c);
    pcSel = sel;
    call  = c;
  endtask

  task automatic load_pc(input logic [31:0] v);
    drive(LOAD, 1'b0);
    newCount = v;
    step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    reset_n = 1'b0; stall = 1'b0; branchTaken = 1'b0; immOffset = '0;
    jumpTarget = '0; regTarget = '0; newCount = '0; drive(SEQ, 1'b0);
    #12;
    vectors++;
    if (currentCount !== 32'h0 || rasCount !== 3'd0 || returnAddr !== 32'h0 ||
        rasOverflow !== 1'b0 || rasUnderflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state pc=%h cnt=%0d ra=%h ovf=%b udf=%b, want 0/0/0/0/0",
               currentCount, rasCount, returnAddr, rasOverflow, rasUnderflow);
    end
    release_reset();
    vectors++;
    if (currentCount !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release_hold pc=%h want 0", currentCount);
    end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      vectors++;
      if (currentCount !== exp_pc || lastFourBits !== 4'h0 || rasCount !== 3'd0) begin
        miscompares++;
        $display("FAIL seq_%0d pc=%h l4=%h cnt=%0d, want pc=%h l4=0 cnt=0",
                 i, currentCount, lastFourBits, rasCount, exp_pc);
      end
    end
  endtask

  task automatic test_branch();
    load_pc(32'h100);
    drive(BRANCH, 1'b1); branchTaken = 1'b1; immOffset = 16'hFFFE;
    step();
    vectors++;
    if (currentCount !== 32'hFC || rasCount !== 3'd0) begin
      miscompares++;
      $display("FAIL branch_taken pc=%h cnt=%0d, want pc=000000fc cnt=0", currentCount, rasCount);
    end
    load_pc(32'h100);
    drive(BRANCH, 1'b0); branchTaken = 1'b0;
    step();
    vectors++;
    if (currentCount !== 32'h104) begin
      miscompares++;
      $display("FAIL branch_not_taken pc=%h want 00000104", currentCount);
    end
    load_pc(32'hFFFF_FFFC);
    drive(SEQ, 1'b0);
    step();
    vectors++;
    if (currentCount !== 32'h0) begin
      miscompares++;
      $display("FAIL seq_wrap pc=%h want 00000000", currentCount);
    end
  endtask

  task automatic test_jump_ret();
    load_pc(32'hA000_0010);
    drive(JUMP, 1'b1); jumpTarget = 26'h0000040;
    step();
    vectors++;
    if (currentCount !== 32'hA000_0100 || returnAddr !== 32'hA000_0014 || rasCount !== 3'd1) begin
      miscompares++;
      $display("FAIL jump_call pc=%h ra=%h cnt=%0d, want a0000100/a0000014/1",
               currentCount, returnAddr, rasCount);
    end
    drive(RET, 1'b0); regTarget = 32'hDEAD_0000;
    step();
    vectors++;
    if (currentCount !== 32'hA000_0014 || rasCount !== 3'd0 || returnAddr !== 32'h0 ||
        rasUnderflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ret_pop pc=%h cnt=%0d ra=%h udf=%b, want a0000014/0/0/0",
               currentCount, rasCount, returnAddr, rasUnderflow);
    end
    drive(3'd6, 1'b1);
    step();
    vectors++;
    if (currentCount !== 32'hA000_0018 || rasCount !== 3'd0) begin
      miscompares++;
      $display("FAIL sel6_as_seq pc=%h cnt=%0d, want a0000018/0", currentCount, rasCount);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rets [4];
    rets = '{32'h5004, 32'h4004, 32'h3004, 32'h2004};
    load_pc(32'h1000);
    for (int i = 0; i < 5; i++) begin
      drive(JREG, 1'b1); regTarget = 32'h2000 + 32'h1000 * i;
      step();
      vectors++;
      if (currentCount !== regTarget || rasOverflow !== (i == 4) ||
          rasCount !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
        miscompares++;
        $display("FAIL nested_call_%0d pc=%h ovf=%b cnt=%0d, want pc=%h ovf=%b",
                 i, currentCount, rasOverflow, rasCount, regTarget, (i == 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(RET, 1'b0); regTarget = 32'hDEAD_0000;
      step();
      vectors++;
      if (currentCount !== rets[i] || rasCount !== 3'(3 - i) || rasUnderflow !== 1'b0) begin
        miscompares++;
        $display("FAIL lifo_ret_%0d pc=%h cnt=%0d udf=%b, want pc=%h cnt=%0d udf=0",
                 i, currentCount, rasCount, rasUnderflow, rets[i], 3 - i);
      end
    end
    drive(RET, 1'b0); regTarget = 32'h7777_0000;
    step();
    vectors++;
    if (currentCount !== 32'h7777_0000 || rasUnderflow !== 1'b1 || rasCount !== 3'd0 ||
        rasOverflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ret_underflow pc=%h udf=%b cnt=%0d ovf=%b, want 77770000/1/0/1",
               currentCount, rasUnderflow, rasCount, rasOverflow);
    end
  endtask

  task automatic test_ret_call();
    drive(RET, 1'b1); regTarget = 32'h8000;
    step();
    vectors++;
    if (currentCount !== 32'h8000 || rasCount !== 3'd1 || returnAddr !== 32'h7777_0004) begin
      miscompares++;
      $display("FAIL ret_call_empty pc=%h cnt=%0d ra=%h, want 00008000/1/77770004",
               currentCount, rasCount, returnAddr);
    end
    drive(RET, 1'b1); regTarget = 32'hDEAD_0000;
    step();
    vectors++;
    if (currentCount !== 32'h7777_0004 || rasCount !== 3'd1 || returnAddr !== 32'h8004) begin
      miscompares++;
      $display("FAIL ret_call_replace pc=%h cnt=%0d ra=%h, want 77770004/1/00008004",
               currentCount, rasCount, returnAddr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; drive(JREG, 1'b1); regTarget = 32'h1234;
    step();
    step();
    vectors++;
    if (currentCount !== 32'h7777_0004 || rasCount !== 3'd1 || returnAddr !== 32'h8004) begin
      miscompares++;
      $display("FAIL stall_hold pc=%h cnt=%0d ra=%h, want 77770004/1/00008004",
               currentCount, rasCount, returnAddr);
    end
    stall = 1'b0; drive(LOAD, 1'b1); newCount = 32'hCD01_23AB;
    step();
    vectors++;
    if (currentCount !== 32'hCD01_23AB || lastFourBits !== 4'hC || rasCount !== 3'd1) begin
      miscompares++;
      $display("FAIL stall_release_load pc=%h l4=%h cnt=%0d, want cd0123ab/c/1",
               currentCount, lastFourBits, rasCount);
    end
    drive(JUMP, 1'b1); jumpTarget = 26'h0;
    step();
    step();
    vectors++;
    if (currentCount !== 32'hC000_0000 || rasCount !== 3'd3 || returnAddr !== 32'hC000_0004) begin
      miscompares++;
      $display("FAIL jump_fill pc=%h cnt=%0d ra=%h, want c0000000/3/c0000004",
               currentCount, rasCount, returnAddr);
    end
  endtask

  task automatic test_async_reset();
    drive(SEQ, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (currentCount !== 32'h0 || rasCount !== 3'd0 || returnAddr !== 32'h0 ||
        rasOverflow !== 1'b0 || rasUnderflow !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset pc=%h cnt=%0d ra=%h ovf=%b udf=%b, want 0/0/0/0/0",
               currentCount, rasCount, returnAddr, rasOverflow, rasUnderflow);
    end
    release_reset();
    step();
    vectors++;
    if (currentCount !== 32'h4 || rasCount !== 3'd0 || returnAddr !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_seq pc=%h cnt=%0d ra=%h, want 00000004/0/0",
               currentCount, rasCount, returnAddr);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_ret();
    test_overflow();
    test_ret_call();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
